// File: rtl/counter_countdown_pkg.sv
// counter_countdown_pkg
//   Shared types and constants for the reloadable down-counter.
//   state_t     : control FSM encoding (IDLE / RUN)
//   IMPL_BORROW : decrement as cnt - ena (borrow-in style)
//   IMPL_MUX    : decrement as ena ? cnt - 1 : cnt (multiplexer style)
package counter_countdown_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int IMPL_BORROW = 0;
    localparam int IMPL_MUX    = 1;

endpackage

// File: rtl/counter_countdown_if.sv
// counter_countdown_if
//   Configuration handshake between a period source and the down-counter.
//   cfg_vld : period/mode offered (master -> slave)
//   cfg_rdy : counter idle and able to accept (slave -> master)
//   cfg_prd : period; expiry every cfg_prd+1 enabled ticks
//   cfg_rpt : 1 = reload on expiry, 0 = one-shot
interface counter_countdown_if #(
    parameter int WIDTH = 32
);
    logic             cfg_vld;
    logic             cfg_rdy;
    logic [WIDTH-1:0] cfg_prd;
    logic             cfg_rpt;

    modport master (
        output cfg_vld,
        output cfg_prd,
        output cfg_rpt,
        input  cfg_rdy
    );

    modport slave (
        input  cfg_vld,
        input  cfg_prd,
        input  cfg_rpt,
        output cfg_rdy
    );

endinterface

// File: rtl/counter_countdown_datapath.sv
// countdown_datapath
//   Count and period registers of the down-counter.
//   clk, rst : clock, synchronous active-low reset
//   load     : capture prd_i into both count and period registers
//   reload   : restore count from the stored period
//   dec      : decrement count by one (never asserted while count is zero)
//   prd_i    : period to capture on load
//   cnt_o    : current count (registered)
//   zero_o   : count equals zero
module countdown_datapath
    import counter_countdown_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             reload,
    input  logic             dec,
    input  logic [WIDTH-1:0] prd_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] prd_q;
    logic [WIDTH-1:0] cnt_dec;

    // Two decrement styles that must behave identically at the ports;
    // with dec low both leave the count unchanged.
    generate
        case (IMPLEMENTATION)
            IMPL_BORROW: begin : g_borrow
                assign cnt_dec = cnt_q - WIDTH'(dec);
            end
            IMPL_MUX: begin : g_mux
                assign cnt_dec = dec ? (cnt_q - WIDTH'(1)) : cnt_q;
            end
            default: begin : g_bad
                $fatal(1, "countdown_datapath: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
                assign cnt_dec = cnt_q;
            end
        endcase
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            prd_q <= '0;
        end else if (load) begin
            cnt_q <= prd_i;
            prd_q <= prd_i;
        end else if (reload) begin
            cnt_q <= prd_q;
        end else begin
            cnt_q <= cnt_dec;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/counter_countdown.sv
// counter_countdown
//   Reloadable down-counter / programmable timer.
//   clk  : clock
//   rst  : synchronous reset, active low
//   ena  : tick enable, one decrement per enabled cycle while running
//   stp  : abort the running count (count frozen, no reload)
//   cfg  : period/mode handshake (slave side)
//   cnt  : current count (registered)
//   bsy  : counter running
//   pls  : one-cycle expiry pulse, same cycle as the expiring tick
module counter_countdown
    import counter_countdown_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                stp,
    counter_countdown_if.slave  cfg,
    output logic [WIDTH-1:0]    cnt,
    output logic                bsy,
    output logic                pls
);

    state_t state_q;
    logic   rpt_q;
    logic   bsy_q;

    logic   zero;
    logic   running;
    logic   expire;
    logic   accept;
    logic   dp_reload;
    logic   dp_dec;

    assign running = (state_q == RUN);
    assign expire  = running & ena & zero;
    // Ready depends on the state register only, never on cfg_vld.
    assign cfg.cfg_rdy = (state_q == IDLE) & rst;
    assign accept  = cfg.cfg_vld & cfg.cfg_rdy;

    // A stop wins over both reload and decrement: the count freezes as-is.
    assign dp_reload = expire & rpt_q & ~stp;
    assign dp_dec    = running & ena & ~zero & ~stp;

    countdown_datapath #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .reload (dp_reload),
        .dec    (dp_dec),
        .prd_i  (cfg.cfg_prd),
        .cnt_o  (cnt),
        .zero_o (zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rpt_q   <= 1'b0;
            bsy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg.cfg_vld) begin
                        state_q <= RUN;
                        rpt_q   <= cfg.cfg_rpt;
                        bsy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (stp || (expire && !rpt_q)) begin
                        state_q <= IDLE;
                        bsy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    bsy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced low for the whole cycle in which reset is held,
    // so a mid-run reset never shows busy or a pulse.
    assign bsy = bsy_q & rst;
    assign pls = expire & rst;

endmodule

// File: tb/tb_counter_countdown.sv
module tb_counter_countdown;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b0;
    logic         stp = 1'b0;
    logic         vld = 1'b0;
    logic         rpt = 1'b0;
    logic [W-1:0] prd = '0;

    logic [W-1:0] cnt0, cnt1;
    logic         bsy0, bsy1, pls0, pls1;

    int n_cmp = 0;
    int n_bad = 0;
    int npls;
    bit trace_on = 1'b0;

    always #5 clk = ~clk;

    counter_countdown_if #(.WIDTH(W)) if0 ();
    counter_countdown_if #(.WIDTH(W)) if1 ();

    assign if0.cfg_vld = vld;
    assign if0.cfg_prd = prd;
    assign if0.cfg_rpt = rpt;
    assign if1.cfg_vld = vld;
    assign if1.cfg_prd = prd;
    assign if1.cfg_rpt = rpt;

    counter_countdown #(.WIDTH(W), .IMPLEMENTATION(0)) dut0 (
        .clk (clk), .rst (rst), .ena (ena), .stp (stp),
        .cfg (if0.slave), .cnt (cnt0), .bsy (bsy0), .pls (pls0)
    );

    counter_countdown #(.WIDTH(W), .IMPLEMENTATION(1)) dut1 (
        .clk (clk), .rst (rst), .ena (ena), .stp (stp),
        .cfg (if1.slave), .cnt (cnt1), .bsy (bsy1), .pls (pls1)
    );

    // Both decrement styles must produce the same trace every cycle.
    always @(negedge clk) begin
        if (trace_on) begin
            n_cmp++;
            assert ({cnt0, bsy0, pls0, if0.cfg_rdy} === {cnt1, bsy1, pls1, if1.cfg_rdy})
            else begin
                n_bad++;
                $error("FAIL impl_trace: impl0=%h impl1=%h",
                       {cnt0, bsy0, pls0, if0.cfg_rdy}, {cnt1, bsy1, pls1, if1.cfg_rdy});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle, then apply this cycle's inputs and let them settle.
    task automatic cyc(input logic r, input logic e, input logic v, input logic s);
        @(posedge clk);
        #1;
        rst = r; ena = e; vld = v; stp = s;
        #1;
    endtask

    initial begin
        // Reset
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_cnt", cnt0, 0);
        chk("rst_bsy", bsy0, 0);
        chk("rst_rdy", if0.cfg_rdy, 0);
        chk("rst_pls", pls0, 0);
        trace_on = 1'b1;
        cyc(1, 0, 0, 0);
        chk("idle_rdy", if0.cfg_rdy, 1);
        chk("idle_bsy", bsy0, 0);

        // One-shot, prd=3
        prd = 8'd3; rpt = 1'b0;
        cyc(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0);
            chk("os_cnt", cnt0, 3 - i);
            chk("os_pls", pls0, (i == 3));
            chk("os_bsy", bsy0, 1);
            chk("os_rdy", if0.cfg_rdy, 0);
        end

        // Periodic prd=2, accepted in the cycle right after the one-shot
        // expiry; a cfg_vld with prd=7 during RUN must be ignored; stop
        // coincides with the third expiry.
        prd = 8'd2; rpt = 1'b1;
        cyc(1, 1, 1, 0);
        chk("reacc_bsy", bsy0, 0);
        chk("reacc_rdy", if0.cfg_rdy, 1);
        chk("reacc_pls", pls0, 0);
        for (int i = 1; i <= 9; i++) begin
            prd = (i == 5) ? 8'd7 : 8'd2;
            cyc(1, 1, (i == 5), (i == 9));
            chk("per_cnt", cnt0, 2 - ((i - 1) % 3));
            chk("per_pls", pls0, (i % 3 == 0));
            chk("per_rdy", if0.cfg_rdy, 0);
        end
        cyc(1, 0, 0, 0);
        chk("stp0_bsy", bsy0, 0);
        chk("stp0_cnt", cnt0, 0);
        chk("stp0_rdy", if0.cfg_rdy, 1);

        // Gated tick, prd=1 one-shot, ena 1,0,1,0
        prd = 8'd1; rpt = 1'b0;
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        chk("gate_cnt1", cnt0, 1);
        chk("gate_pls1", pls0, 0);
        cyc(1, 0, 0, 0);
        chk("gate_cnt2", cnt0, 0);
        chk("gate_pls2", pls0, 0);
        cyc(1, 1, 0, 0);
        chk("gate_cnt3", cnt0, 0);
        chk("gate_pls3", pls0, 1);
        cyc(1, 0, 0, 0);
        chk("gate_bsy", bsy0, 0);
        chk("gate_pls4", pls0, 0);

        // prd=0 periodic: pulse on every enabled tick
        prd = 8'd0; rpt = 1'b1;
        cyc(1, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1, 0, (i == 4));
            chk("p0_cnt", cnt0, 0);
            chk("p0_pls", pls0, 1);
        end
        cyc(1, 1, 0, 0);
        chk("p0_bsy", bsy0, 0);
        chk("p0_idle_pls", pls0, 0);

        // prd=255 one-shot: pulse after exactly 256 ticks
        prd = 8'd255; rpt = 1'b0;
        cyc(1, 0, 1, 0);
        npls = 0;
        for (int k = 1; k <= 256; k++) begin
            cyc(1, 1, 0, 0);
            if (k == 1)   chk("max_cnt_first", cnt0, 255);
            if (k == 128) chk("max_cnt_mid", cnt0, 128);
            if (k < 256)  npls += int'(pls0);
            if (k == 256) begin
                chk("max_cnt_last", cnt0, 0);
                chk("max_pls", pls0, 1);
            end
        end
        chk("max_early_pls", npls, 0);
        cyc(1, 0, 0, 0);
        chk("max_bsy", bsy0, 0);

        // Stop at cnt=5: count frozen, no reload
        prd = 8'd9; rpt = 1'b1;
        cyc(1, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 1, 0, (k == 5));
            chk("stp5_run_cnt", cnt0, 10 - k);
        end
        cyc(1, 1, 0, 0);
        chk("stp5_cnt", cnt0, 5);
        chk("stp5_bsy", bsy0, 0);
        chk("stp5_rdy", if0.cfg_rdy, 1);
        chk("stp5_pls", pls0, 0);
        cyc(1, 1, 0, 0);
        chk("stp5_hold", cnt0, 5);

        // stp in IDLE is ignored (accept still happens); reset mid-run at cnt=4
        prd = 8'd7; rpt = 1'b1;
        cyc(1, 0, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 1, 0, 0);
            chk("mr_cnt", cnt0, 8 - k);
            chk("mr_bsy", bsy0, 1);
        end
        cyc(0, 1, 0, 0);
        chk("mr_rst_pls", pls0, 0);
        chk("mr_rst_bsy", bsy0, 0);
        chk("mr_rst_rdy", if0.cfg_rdy, 0);
        cyc(1, 0, 0, 0);
        chk("mr_cnt_after", cnt0, 0);
        chk("mr_bsy_after", bsy0, 0);
        chk("mr_rdy_after", if0.cfg_rdy, 1);
        chk("mr_pls_after", pls0, 0);

        @(negedge clk);
        trace_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_countdown.md
# counter_countdown

Reloadable down-counter: the decrementing counterpart to the wrap-on-maximum up-counter in the arithmetic library. A period is loaded through a valid/ready handshake. The block counts down on enabled ticks and emits a one-cycle pulse when it reaches zero. In repeat mode it then reloads; in one-shot mode it stops. It serves as a programmable timer or prescaler beside the up-counters in the same arithmetic group.

## Interface
Parameters:
- WIDTH, 32, counter and period width
- IMPLEMENTATION, 0, decrement style: 0 borrow-in (`cnt - ena`), 1 multiplexer (`if (ena) cnt - 1`); other values are a `$fatal` at elaboration

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- ena  in  1  tick enable; one decrement per cycle with ena=1 while running
- cfg_vld  in  1  configuration valid
- cfg_rdy  out  1  configuration ready
- cfg_prd  in  WIDTH  period; expiry every cfg_prd+1 ticks
- cfg_rpt  in  1  1 = periodic reload, 0 = one-shot
- stp  in  1  stop request; aborts the running count
- cnt  out  WIDTH  current count, registered
- bsy  out  1  running (state RUN)
- pls  out  1  expiry pulse

## Operation
- States:
  - IDLE: cfg_rdy=1, cnt held.
  - RUN: cfg_rdy=0, bsy=1.
- Accept: cfg_vld & cfg_rdy at a clock edge. On that edge:
  - cnt ← cfg_prd
  - prd_r ← cfg_prd
  - rpt_r ← cfg_rpt
  - state → RUN
- RUN with ena=1 and cnt≠0: cnt ← cnt−1.
- RUN with ena=1 and cnt=0 (expiry): pls=1.
  - rpt_r=1: cnt ← prd_r, stay in RUN.
  - rpt_r=0: cnt stays 0, state → IDLE.
- RUN with ena=0: cnt held, pls=0.
- stp=1 in RUN: state → IDLE at the next edge, cnt frozen at its current value, no reload.
- stp=1 together with expiry: pls still asserts (expiry is reported), state → IDLE, no reload.
- stp=1 in IDLE: ignored.
- cfg_prd=0:
  - Periodic: pls on every enabled tick.
  - One-shot: pls on the first enabled tick after accept.
- cfg_prd=2^WIDTH−1 is a legal period; no arithmetic overflow is possible because decrement never occurs at 0.
- cfg_vld while in RUN is not accepted; the input is held off by cfg_rdy=0.
- Both IMPLEMENTATION values are cycle-identical at the ports.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE, cnt=0, prd_r=0, rpt_r=0.
  - While rst=0: cfg_rdy=0, bsy=0, pls=0.
- cfg_rdy = (state==IDLE) & rst. It is combinational from the state register only; it has no dependence on cfg_vld.
- The first decrement can happen in the cycle after accept, i.e. accept edge N, first ena counted at edge N+1.
- pls = (state==RUN) & ena & (cnt==0) & rst. It is combinational, asserted in the same cycle as the expiring tick, and lasts one cycle per expiry.
- Expiry period: with ena held high, pls every prd+1 cycles.
- One-shot to re-accept:
  - Expiry at edge E: bsy low and cfg_rdy high from cycle E+1.
  - New accept at E+1 starts the count at E+2.
- Reset mid-run: the count is discarded and no pls is emitted in the reset cycle. The block returns to IDLE after the edge.
- bsy is registered (state==RUN). It falls in the cycle after the stp or one-shot expiry edge.

## Structure
- Package `counter_countdown_pkg`:
  - typedef enum logic {IDLE, RUN} state_t
  - localparams IMPL_BORROW=0 and IMPL_MUX=1
- Sub-module `countdown_datapath`:
  - Holds cnt and prd_r, with the generate case over IMPLEMENTATION.
  - Inputs: load, reload, dec; output: zero flag.
  - The top level holds the state machine, handshake and pls/bsy logic.
- Parameter validation uses `$fatal` in the datapath's default generate branch.

## Test plan
- Reset then one-shot: WIDTH=8, accept prd=3, rpt=0, ena=1 continuous. Required:
  - cnt 3,2,1,0
  - pls in the 4th cycle after accept
  - bsy low and cfg_rdy high the next cycle
- Periodic, prd=2, ena=1, 9 cycles → pls at cycles 3, 6 and 9 after accept; cnt sequence 2,1,0,2,1,0,…
- Gated tick, prd=1, ena toggling 1,0,1,0 → cnt holds on ena=0; pls only on the 2nd enabled tick.
- Boundaries:
  - prd=0 periodic → pls every ena cycle.
  - prd=255 one-shot → pls after exactly 256 ticks.
  - cfg_vld during RUN → not accepted.
- stp=1 with cnt=0 and ena=1 (periodic): pls=1 that cycle, then IDLE with no reload. Separately, stp at cnt=5 → IDLE with cnt=5 held.
- rst=0 mid-run at cnt=4 → next cycle cnt=0, bsy=0, no pls. Run both IMPLEMENTATION values and compare traces for equality.
